// File: rtl/mig_sched_pkg.sv
// mig_sched_pkg: shared types and constants for the MIG read/write scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mig_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } sched_state_e;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // Consecutive ineligible cycles after which an active grant is given up.
  localparam int unsigned IDLE_LIMIT = 4;

endpackage

// File: rtl/phrase_fifo.sv
// phrase_fifo: synchronous FIFO holding read-return phrases, with occupancy count.
// Latency: a pushed phrase is visible on pop_dat_o the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk_in/rst_in; push_i/push_dat_i write side; pop_i/pop_dat_o/vld_o read side; count_o occupancy.
module phrase_fifo #(
  parameter int unsigned  WIDTH = 128,
  parameter int unsigned  DEPTH = 128,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             vld_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem[rd_ptr_q];
  assign vld_o     = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/rollover_addr.sv
// rollover_addr: address counter stepping by STEP, wrapping from LAST back to 0.
// Latency: new address visible the cycle after inc_i.
// Backpressure: none; advances only when inc_i is high.
// Ports: clk_in/rst_in clock and sync reset; inc_i advance strobe; addr_o current address.
module rollover_addr #(
  parameter int unsigned   AW   = 27,
  parameter logic [AW-1:0] STEP = AW'(8),
  parameter logic [AW-1:0] LAST = AW'(0)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (inc_i) begin
      // Wrap exactly after the last step so no address is skipped or repeated.
      addr_d = (addr_q == LAST) ? '0 : addr_q + STEP;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mig_rw_scheduler.sv
// mig_rw_scheduler: shares one MIG user port between a write phrase stream and frame
//   read-back, granting each side bursts of up to BURST_LEN commands in turn.
// Latency: commands issue combinationally in grant cycles (one IDLE cycle between grants);
//   returned read data is on rd_* the cycle after app_rd_data_valid.
// Backpressure: writes wait on wr_ready; reads stop issuing once in-flight plus buffered
//   phrases reach RD_DEPTH, so rd_ready=0 eventually throttles the MIG read stream.
// Ports: clk_in/rst_in; wr_valid/wr_ready/wr_data write stream; rd_valid/rd_ready/rd_data
//   read stream; app_* MIG native user interface (command, write data, read data).
module mig_rw_scheduler
  import mig_sched_pkg::*;
#(
  parameter int unsigned FRAME_PHRASES = 9600,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned RD_DEPTH      = 128,
  parameter int unsigned ADDR_INCR     = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [127:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_data,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid
);

  localparam int unsigned CW = $clog2(RD_DEPTH + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [26:0] ADDR_STEP = 27'(ADDR_INCR);
  localparam logic [26:0] ADDR_LAST = 27'(FRAME_PHRASES * ADDR_INCR - ADDR_INCR);

  sched_state_e  state_q, state_d;
  logic          last_wr_q, last_wr_d;   // 1: the most recent grant was a write grant
  logic [BW-1:0] burst_q, burst_d;
  logic [2:0]    stall_q, stall_d;       // consecutive cycles the active side was ineligible
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] occ;
  logic [CW:0]   inflight;
  logic [26:0]   wr_addr, rd_addr;
  logic          wr_elig, rd_elig, act_elig, oth_elig;
  logic          wr_issue, rd_issue, rd_accept;

  // Reserving buffer space at issue time keeps the return buffer from ever overflowing.
  assign inflight = {1'b0, outst_q} + {1'b0, occ};
  assign wr_elig  = wr_valid;
  assign rd_elig  = inflight < (CW + 1)'(RD_DEPTH);

  assign wr_issue  = !rst_in && (state_q == ST_WRITE) && wr_valid && app_rdy && app_wdf_rdy;
  assign rd_issue  = !rst_in && (state_q == ST_READ) && rd_elig && app_rdy;
  // Returns with nothing outstanding are stale (e.g. issued before a reset) and dropped.
  assign rd_accept = app_rd_data_valid && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    case ({rd_issue, rd_accept})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    burst_d   = burst_q;
    stall_d   = stall_q;
    act_elig  = 1'b0;
    oth_elig  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        stall_d = '0;
        // On contention the side not granted last wins.
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          state_d   = ST_WRITE;
          last_wr_d = 1'b1;
        end else if (rd_elig) begin
          state_d   = ST_READ;
          last_wr_d = 1'b0;
        end
      end
      ST_WRITE, ST_READ: begin
        act_elig = (state_q == ST_WRITE) ? wr_elig : rd_elig;
        oth_elig = (state_q == ST_WRITE) ? rd_elig : wr_elig;
        if (wr_issue || rd_issue) burst_d = burst_q + BW'(1);
        stall_d = act_elig ? 3'd0 : stall_q + 3'd1;
        if (((wr_issue || rd_issue) && (burst_q == BW'(BURST_LEN - 1))) ||
            (!act_elig && (oth_elig || (stall_q == 3'(IDLE_LIMIT - 1))))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      burst_q   <= '0;
      stall_q   <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      burst_q   <= burst_d;
      stall_q   <= stall_d;
      outst_q   <= outst_d;
    end
  end

  rollover_addr #(.AW(27), .STEP(ADDR_STEP), .LAST(ADDR_LAST)) u_wr_addr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc_i  (wr_issue),
    .addr_o (wr_addr)
  );

  rollover_addr #(.AW(27), .STEP(ADDR_STEP), .LAST(ADDR_LAST)) u_rd_addr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc_i  (rd_issue),
    .addr_o (rd_addr)
  );

  phrase_fifo #(.WIDTH(128), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_i     (rd_accept),
    .push_dat_i (app_rd_data),
    .pop_i      (rd_ready),
    .pop_dat_o  (rd_data),
    .vld_o      (rd_valid),
    .count_o    (occ)
  );

  assign app_en       = wr_issue || rd_issue;
  assign app_wdf_wren = wr_issue;
  assign app_wdf_end  = wr_issue;   // one 128-bit phrase per write command
  assign wr_ready     = wr_issue;
  assign app_wdf_data = wr_data;
  assign app_cmd      = (state_q == ST_READ) ? MIG_CMD_READ : MIG_CMD_WRITE;
  assign app_addr     = (state_q == ST_READ) ? rd_addr : wr_addr;

endmodule

// File: tb/tb_mig_rw_scheduler.sv
module tb_mig_rw_scheduler;
  import mig_sched_pkg::*;

  localparam int unsigned FP  = 4;
  localparam int unsigned BL  = 4;
  localparam int unsigned RDD = 8;
  localparam int unsigned AI  = 8;
  localparam int unsigned FRAME_SPAN = FP * AI;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_in, wr_valid, wr_ready, rd_valid, rd_ready;
  logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
  logic [127:0] wr_data, rd_data, app_wdf_data, app_rd_data;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;

  // Second instance: long bursts, write stream always offered, for back-to-back writes.
  logic         wo_wr_ready, wo_rd_valid, wo_app_en, wo_app_wdf_wren, wo_app_wdf_end;
  logic [127:0] wo_rd_data, wo_app_wdf_data;
  logic [26:0]  wo_app_addr;
  logic [2:0]   wo_app_cmd;
  logic [127:0] wo_wr_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  mig_rw_scheduler #(.FRAME_PHRASES(FP), .BURST_LEN(BL), .RD_DEPTH(RDD), .ADDR_INCR(AI)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  mig_rw_scheduler #(.FRAME_PHRASES(FP), .BURST_LEN(64), .RD_DEPTH(RDD), .ADDR_INCR(AI)) u_dut_wo (
    .clk_in(clk_in), .rst_in(rst_in),
    .wr_valid(1'b1), .wr_ready(wo_wr_ready), .wr_data(wo_wr_data),
    .rd_valid(wo_rd_valid), .rd_ready(1'b0), .rd_data(wo_rd_data),
    .app_addr(wo_app_addr), .app_cmd(wo_app_cmd), .app_en(wo_app_en), .app_rdy(1'b1),
    .app_wdf_data(wo_app_wdf_data), .app_wdf_wren(wo_app_wdf_wren), .app_wdf_end(wo_app_wdf_end),
    .app_wdf_rdy(1'b1), .app_rd_data(128'h0), .app_rd_data_valid(1'b0)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle.
  logic n_rst, n_wv, n_rr, n_ardy, n_awrdy;
  bit   spur_en;
  int   lat;
  int   cyc;

  // Reference model: transaction-level view of the scheduler.
  int           m_wr_addr, m_rd_addr, m_out;
  logic [127:0] m_q[$];
  logic [127:0] cur_phrase;
  int           mig_due[$];
  int           rd_issues;
  bit           obs_wr, obs_rd;
  logic [26:0]  obs_addr;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic monitor();
    bit wi, ri, ret_ok;
    int due;
    wi = app_en && (app_cmd == MIG_CMD_WRITE);
    ri = app_en && (app_cmd == MIG_CMD_READ);
    obs_wr = wi; obs_rd = ri; obs_addr = app_addr;
    if (rst_in) begin
      chk("rst_app_en", app_en, 1'b0);
      chk("rst_wdf_wren", app_wdf_wren, 1'b0);
      chk("rst_wdf_end", app_wdf_end, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      m_wr_addr = 0; m_rd_addr = 0; m_out = 0; m_q.delete(); rd_issues = 0;
      return;
    end
    chk("rd_valid", rd_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
    chk("wr_ready", wr_ready, wi);
    chk("wdf_wren", app_wdf_wren, wi);
    chk("wdf_end", app_wdf_end, wi);
    if (app_en) begin
      chk("en_without_rdy", app_rdy, 1'b1);
      chk("cmd_legal", wi | ri, 1'b1);
    end
    if (wi) begin
      chk("wr_when_invalid", wr_valid, 1'b1);
      chk("wr_when_wdf_full", app_wdf_rdy, 1'b1);
      chk("wr_addr", app_addr, m_wr_addr);
      chk("wdf_data", app_wdf_data, cur_phrase);
      m_wr_addr = (m_wr_addr + AI) % FRAME_SPAN;
      cur_phrase = rnd128();
    end
    if (ri) begin
      chk("rd_addr", app_addr, m_rd_addr);
      chk("rd_eligible", (m_out + m_q.size()) < RDD, 1'b1);
      m_rd_addr = (m_rd_addr + AI) % FRAME_SPAN;
      due = cyc + lat;
      if (mig_due.size() != 0 && due <= mig_due[$]) due = mig_due[$] + 1;
      mig_due.push_back(due);
      rd_issues++;
    end
    ret_ok = app_rd_data_valid && (m_out > 0);
    if (m_q.size() != 0 && rd_ready) void'(m_q.pop_front());
    if (ret_ok) m_q.push_back(app_rd_data);
    m_out = m_out + (ri ? 1 : 0) - (ret_ok ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    rst_in = n_rst; wr_valid = n_wv; rd_ready = n_rr;
    app_rdy = n_ardy; app_wdf_rdy = n_awrdy; wr_data = cur_phrase;
    app_rd_data_valid = 1'b0;
    app_rd_data = rnd128();
    if (mig_due.size() != 0 && mig_due[0] <= cyc) begin
      void'(mig_due.pop_front());
      app_rd_data_valid = 1'b1;
    end else if (spur_en && mig_due.size() == 0 && m_out == 0 && $urandom_range(15) == 0) begin
      app_rd_data_valid = 1'b1;
    end
    @(negedge clk_in);
    monitor();
  endtask

  // Let in-flight MIG reads land, then reset; the next tick is the first IDLE cycle.
  task automatic do_reset();
    n_ardy = 1'b0; n_wv = 1'b0;
    for (int i = 0; i < 60 && mig_due.size() != 0; i++) tick();
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
  endtask

  initial begin
    bit exp_w, exp_r, done;
    int k, nw;
    rst_in = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0; wr_data = '0;
    n_rst = 1'b1; n_wv = 1'b0; n_rr = 1'b1; n_ardy = 1'b0; n_awrdy = 1'b1;
    spur_en = 1'b0; lat = 3; cyc = 0; cur_phrase = rnd128();
    m_wr_addr = 0; m_rd_addr = 0; m_out = 0; rd_issues = 0;
    tick(); tick();
    n_rst = 1'b0;

    // Back-to-back writes on the long-burst instance, wrapping after 4 phrases.
    chk("reset_rd_valid", rd_valid, 1'b0);
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c == 0) chk("wo_first_idle", wo_app_en, 1'b0);
      else begin
        chk("wo_issue", wo_app_en, 1'b1);
        chk("wo_cmd", wo_app_cmd, MIG_CMD_WRITE);
        chk("wo_addr", wo_app_addr, ((c - 1) * AI) % FRAME_SPAN);
        chk("wo_data", wo_app_wdf_data, wo_wr_data);
      end
      chk("wo_wr_ready", wo_wr_ready, wo_app_en);
    end

    // Arbitration: 4 writes, IDLE, 4 reads, IDLE, ... starting with writes.
    do_reset();
    n_wv = 1'b1; n_rr = 1'b1; n_ardy = 1'b1; n_awrdy = 1'b1; lat = 3;
    for (int c = 0; c < 30; c++) begin
      tick();
      k = (c - 1) % 10;
      exp_w = (c >= 1) && (k < 4);
      exp_r = (c >= 1) && (k >= 5) && (k < 9);
      chk("arb_write", obs_wr, exp_w);
      chk("arb_read", obs_rd, exp_r);
    end

    // Stall: app_rdy 1,0,0,1 repeating inside a write grant.
    do_reset();
    n_wv = 1'b1; n_rr = 1'b1; n_awrdy = 1'b1; nw = 0;
    for (int c = 0; c < 9; c++) begin
      n_ardy = (c == 0) || ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      tick();
      if (c >= 1) begin
        chk("stall_issue", obs_wr, n_ardy);
        if (obs_wr) begin
          chk("stall_addr", obs_addr, nw * AI);
          nw++;
        end
      end
    end
    chk("stall_write_count", nw, 4);

    // Backpressure: no downstream pops, 10-cycle MIG read latency.
    do_reset();
    n_rr = 1'b0; n_ardy = 1'b1; lat = 10;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c >= 12) chk("bp_rd_valid", rd_valid, 1'b1);
    end
    chk("bp_read_count", rd_issues, 8);
    n_rr = 1'b1;
    for (int c = 0; c < 12; c++) tick();

    // Reset with three reads in flight: their returns must be dropped.
    do_reset();
    n_rr = 1'b1; n_ardy = 1'b1; lat = 10; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      done = (rd_issues == 3);
    end
    chk("rst_three_issued", done, 1'b1);
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0; n_ardy = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("rst_drop_rd_valid", rd_valid, 1'b0);
    end
    chk("rst_returns_seen", mig_due.size(), 0);
    n_ardy = 1'b1; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      if (obs_rd) begin
        done = 1'b1;
        chk("rst_rd_addr0", obs_addr, 27'd0);
      end
    end
    chk("rst_read_resumed", done, 1'b1);

    // Randomized traffic against the model.
    spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      n_wv    = ($urandom_range(3) != 0);
      n_rr    = ($urandom_range(2) != 0);
      n_ardy  = ($urandom_range(3) != 0);
      n_awrdy = ($urandom_range(3) != 0);
      n_rst   = ($urandom_range(599) == 0);
      if ($urandom_range(63) == 0) lat = $urandom_range(12, 1);
      tick();
    end
    n_rst = 1'b0; n_wv = 1'b0; n_rr = 1'b1; spur_en = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
